// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Exhaustive sweep of a 2-input combinational gate. Drives the
//               four input vectors in order, waits SETTLE cycles per vector,
//               samples the gate output against the TRUTH table and reports
//               an error count, a per-vector fail mask and a pass flag.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out_dut,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last value of the settle counter; WAIT leaves on the edge it is reached.
  localparam logic [7:0] c_cnt_last = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       in1_q, in1_d;
  logic       in2_q, in2_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic: sweep sequencing, settle timing and result accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start is only honoured when no sweep is running
        if (start) begin
          state_d = ST_WAIT;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          in1_d   = 1'b0;
          in2_d   = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
        end
      end
      ST_WAIT: begin
        // counter holds at its last value so it never exceeds SETTLE-1
        if (cnt_q == c_cnt_last) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (out_dut != TRUTH[idx_q]) begin
          err_d         = err_q + 3'd1;
          fail_d[idx_q] = 1'b1;
        end
        if (idx_q != 2'd3) begin
          idx_d          = idx_q + 2'd1;
          {in1_d, in2_d} = idx_q + 2'd1;
          cnt_d          = 8'd0;
          state_d        = ST_WAIT;
        end else begin
          // inputs stay at 2'b11 once the sweep completes
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_q == 3'd0);
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Randomised self-checking bench for gate_sweep_ctrl. Two
//               instances (AND/SETTLE=2 and XOR/SETTLE=1) share start/rst;
//               each gate under test is emulated by a random truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;

  // Emulated gate behaviour per instance: output = tbl[{in1,in2}]
  logic [3:0] tbl [2];

  logic       a_out, a_in1, a_in2, a_busy, a_done, a_pass;
  logic [2:0] a_err;
  logic [3:0] a_fail;
  logic       b_out, b_in1, b_in2, b_busy, b_done, b_pass;
  logic [2:0] b_err;
  logic [3:0] b_fail;

  always #5 clk = ~clk;

  gate_sweep_ctrl #(.TRUTH(4'b1000), .SETTLE(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .out_dut(a_out),
    .in1(a_in1), .in2(a_in2), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .fail_vec(a_fail)
  );

  gate_sweep_ctrl #(.TRUTH(4'b0110), .SETTLE(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .out_dut(b_out),
    .in1(b_in1), .in2(b_in2), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .fail_vec(b_fail)
  );

  assign a_out = tbl[0][{a_in1, a_in2}];
  assign b_out = tbl[1][{b_in1, b_in2}];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_value(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (word = in1 in2 busy done pass err[2:0] fail[3:0]) at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = sweeping, 2 = done.
  // t counts edges since the accepted start; msk = vectors that will mismatch.
  int         settle [2] = '{2, 1};
  logic [3:0] truth  [2] = '{4'b1000, 4'b0110};
  int         ph     [2];
  int         t      [2];
  logic [3:0] msk    [2];

  function automatic logic [11:0] exp_word(input int i);
    int         per;
    int         ns;
    logic [3:0] f;
    logic [1:0] v;
    logic [11:0] w;
    per = settle[i] + 1;
    w   = 12'h000;
    if (ph[i] == 2) begin
      f = msk[i];
      w = {2'b11, 1'b0, 1'b1, (f == 4'd0), 3'($countones(f)), f};
    end else if (ph[i] == 1) begin
      ns = t[i] / per;                 // vectors already sampled
      v  = 2'(ns);                     // vector currently driven
      f  = msk[i] & 4'((1 << ns) - 1);
      w  = {v, 1'b1, 1'b0, 1'b0, 3'($countones(f)), f};
    end
    return w;
  endfunction

  task automatic model_step(input int i);
    if (rst) begin
      ph[i] = 0;
      t[i]  = 0;
    end else if (ph[i] != 1 && start) begin
      ph[i]  = 1;
      t[i]   = 0;
      msk[i] = truth[i] ^ tbl[i];
    end else if (ph[i] == 1) begin
      t[i]++;
      if (t[i] == 4 * (settle[i] + 1)) ph[i] = 2;
    end
  endtask

  function automatic logic [3:0] pick_tbl(input int i);
    logic [3:0] r;
    case ($urandom_range(0, 3))
      0:       r = truth[i];
      1:       r = 4'b0000;
      2:       r = 4'b1111;
      default: r = 4'($urandom);
    endcase
    return r;
  endfunction

  // Stimulus phases: sparse pulses, start held high, dense random, rare pulses.
  initial begin
    int mode;
    rst    = 1'b1;
    start  = 1'b0;
    tbl[0] = 4'b1000;
    tbl[1] = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; t[i] = 0; msk[i] = 4'd0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      chk_value("A_and_s2", {a_in1, a_in2, a_busy, a_done, a_pass, a_err, a_fail}, exp_word(0));
      chk_value("B_xor_s1", {b_in1, b_in2, b_busy, b_done, b_pass, b_err, b_fail}, exp_word(1));
      mode = (cyc / 250) % 4;
      rst  = (cyc < 2) || ($urandom_range(0, 199) == 0);
      case (mode)
        0:       start = ($urandom_range(0, 19) == 0);
        1:       start = 1'b1;
        2:       start = $urandom_range(0, 1) == 1;
        default: start = ($urandom_range(0, 59) == 0);
      endcase
      for (int i = 0; i < 2; i++) begin
        if (ph[i] != 1 && $urandom_range(0, 3) == 0) tbl[i] = pick_tbl(i);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exhaustively exercises a 2-input combinational gate (and2 and sibling gates) in hardware. On `start` it drives all four input vectors {in1,in2} = 0..3 in order, waits a programmable settle time per vector, samples the gate output, and compares it against a parameterised truth table. It reports an error count, a per-vector fail mask and a pass flag. It sits between a top-level control (button or host register) and the gate under test.

## Interface
- `TRUTH`, default 4'b1000: expected output; bit `TRUTH[idx]` is the expected output for {in1,in2} = idx. 4'b1000 = AND, 4'b1110 = OR, 4'b0110 = XOR.
- `SETTLE`, default 2: cycles inputs are held before sampling. Legal values are 1 to 255.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a sweep. Sampled in IDLE or DONE only.
- `out_dut` input 1: output of the gate under test.
- `in1` output 1: gate input A; registered, equals idx[1].
- `in2` output 1: gate input B; registered, equals idx[0].
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: high from sweep completion until the next accepted `start` or `rst`.
- `pass` output 1: equals `done` AND (`err_count` == 0).
- `err_count` output 3: number of mismatching vectors, 0 to 4.
- `fail_vec` output 4: bit idx is set if vector idx mismatched.

## Operation
- States are IDLE, WAIT, SAMPLE and DONE. Internal registers are `idx` (2 bits) and `cnt` (8 bits).
- **Reset:** state goes to IDLE. `idx`, `cnt`, `in1`, `in2`, `busy`, `done`, `err_count` and `fail_vec` all go to 0, so `pass` is 0. `rst` overrides every other input, including mid-sweep.
- **IDLE or DONE with `start`=1:**
  - Next state is WAIT.
  - `idx`, `cnt`, `err_count` and `fail_vec` clear to 0; {in1,in2} goes to 2'b00.
  - `busy` goes to 1 and `done` goes to 0.
- **IDLE or DONE with `start`=0:** hold all state and outputs.
- **WAIT:** `cnt` increments each cycle. On the edge where `cnt` == SETTLE-1, the next state is SAMPLE. WAIT therefore lasts exactly SETTLE cycles.
- **SAMPLE:** compare `out_dut` with `TRUTH[idx]`. On mismatch, `err_count` increments and `fail_vec[idx]` is set.
  - If `idx` != 3: `idx` increments, {in1,in2} takes the new `idx`, `cnt` clears to 0, and the next state is WAIT.
  - If `idx` == 3: the next state is DONE, `busy` goes to 0 and `done` goes to 1. {in1,in2} holds 2'b11.
- **`start` while busy** (WAIT or SAMPLE): ignored and has no effect.
- **`start` held high continuously:** one sweep runs, then a new sweep starts on the first edge in DONE. `done` is high for exactly one cycle between sweeps.
- **Arithmetic limits:** `err_count` cannot exceed 4 and needs no saturation. `cnt` never exceeds SETTLE-1.
- **No wrap:** `idx` never wraps during a sweep; the sweep ends at 3.

## Timing
- Edge E0 is the one that accepts `start`.
  - {in1,in2} = 00 is valid after E0.
  - Vector k is sampled on edge E0 + (k+1)·(SETTLE+1).
  - The new {in1,in2} = k+1 is driven on that same edge.
- `done`, `pass` and final results are valid after E0 + 4·(SETTLE+1). With SETTLE=2 this is 12 cycles.
- `out_dut` must be stable within SETTLE cycles of an input change. It is sampled in the SAMPLE cycle, SETTLE+1 cycles after the input was driven.
- Result outputs (`err_count`, `fail_vec`) update during the sweep. They are final only when `done`=1.
- **Reset mid-sweep:** all outputs read 0 after the reset edge, and no partial results are retained.

## Test plan
- **Ideal AND** (TRUTH=4'b1000, SETTLE=2, `out_dut` = in1&in2), pulse `start` → inputs step 00, 01, 10, 11 at 3-cycle spacing. `done`=1 exactly 12 cycles after the start edge, with `pass`=1, `err_count`=0, `fail_vec`=4'b0000.
- **Stuck-at-0 gate** (`out_dut`=0) → `err_count`=1, `fail_vec`=4'b1000, `pass`=0. **Stuck-at-1 gate** (`out_dut`=1) → `err_count`=3, `fail_vec`=4'b0111.
- **`start` pulsed at cycles 3 and 7 of a running sweep** → no restart. Completion is still 12 cycles after the original start edge with identical results. Then `start` from DONE → results clear, `done`=0, `busy`=1, and a new sweep completes 12 cycles later.
- **`rst` asserted one cycle while `idx`=2 in WAIT** → next cycle has `busy`, `done`, `in1`, `in2`, `err_count`, `fail_vec` all 0 and state IDLE. `start` afterwards gives a full normal sweep.
- **SETTLE=1, TRUTH=4'b0110** with an XOR model → samples every 2 cycles, `done` after 8 cycles, `pass`=1. With an AND model instead → `err_count`=3, `fail_vec`=4'b1110.
- **`start` tied high** → back-to-back sweeps, `done` high for exactly 1 cycle every 13 cycles, `busy` low only during that cycle.
